scroll_queue: RTL

- Parametrised successor to the single-game scroll controller: a queue of ROWS digit rows, each DIGITS nibbles wide, scrolled upward by a pixel displacement that advances once per video frame.
- Problems arrive from an external generator over a valid/ready handshake into a one-entry buffer.
- Answers from the digit classifier arrive over a valid/ready handshake and are checked against the active row's expected nibble.
- Per-row correctness marks and a saturating score are kept; o_rows, o_mark, o_marked and o_displacement feed display_nums.

---
 rtl/scroll_queue_pkg.sv | 18 +
 rtl/scroll_queue_problem_buffer.sv | 46 ++++
 rtl/scroll_queue.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/scroll_queue_pkg.sv
// Shared types and codes for the scrolling problem queue.
// Imported by the queue top and its problem buffer.
package scroll_pkg;

  typedef enum logic [1:0] {
    S_PRIME,
    S_IDLE,
    S_SCROLL
  } state_t;

  localparam logic [3:0] BLANK_NIB = 4'hd;
  localparam logic [3:0] RESET_NIB = 4'hf;

  localparam int PKG_DIGITS = 6;

  typedef logic [PKG_DIGITS*4-1:0] row_t;

endpackage

// File: rtl/scroll_queue_problem_buffer.sv
// One-entry valid/ready holding register for incoming problems.
// Ready only while empty, so accept and consume never coincide.
module problem_buffer
  import scroll_pkg::*;
#(
  parameter int DW = PKG_DIGITS*4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          consume,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  assign in_ready  = !valid_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid && !valid_q) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/scroll_queue.sv
// Queue of digit rows scrolled upward one pixel step per frame,
// with answer checking on the active row and a saturating score.
module scroll_queue
  import scroll_pkg::*;
#(
  parameter int         ROWS        = 4,
  parameter int         DIGITS      = 6,
  parameter int         ACTIVE_ROW  = 2,
  parameter int         ANS_NIBBLE  = 0,
  parameter int         ROW_HEIGHT  = 150,
  parameter int         SCROLL_STEP = 3,
  parameter int         SCORE_W     = 8,
  parameter logic [3:0] BLANK       = BLANK_NIB,
  parameter logic [3:0] RESET_FILL  = RESET_NIB
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_frame_tick,
  input  logic                     i_problem_valid,
  input  logic [DIGITS*4-1:0]      i_problem,
  output logic                     o_problem_ready,
  input  logic                     i_answer_valid,
  input  logic [3:0]               i_answer_digit,
  output logic                     o_answer_ready,
  output logic [ROWS*DIGITS*4-1:0] o_rows,
  output logic [ROWS-1:0]          o_mark,
  output logic [ROWS-1:0]          o_marked,
  output logic [10:0]              o_displacement,
  output logic [SCORE_W-1:0]       o_score,
  output logic                     o_busy
);

  localparam int DW = DIGITS*4;
  localparam int PW = (ROWS > 2) ? $clog2(ROWS) : 1;
  localparam logic [DW-1:0] RESET_ROW = {DIGITS{RESET_FILL}};
  localparam logic [DW-1:0] BLANK_ROW = {DIGITS{BLANK}};
  localparam logic [PW-1:0] PRIME_START = PW'(ACTIVE_ROW);

  state_t               state_q, state_d;
  logic [PW-1:0]        prime_idx_q, prime_idx_d;
  logic [DW-1:0]        rows_q [ROWS];
  logic [DW-1:0]        rows_d [ROWS];
  logic [ROWS-1:0]      mark_q, mark_d;
  logic [ROWS-1:0]      marked_q, marked_d;
  logic [10:0]          disp_q, disp_d;
  logic [SCORE_W-1:0]   score_q, score_d;

  logic                 buf_valid;
  logic [DW-1:0]        buf_data;
  logic                 consume;
  logic                 ans_take;
  logic                 match;
  logic [3:0]           exp_nib;
  logic [11:0]          disp_sum;

  problem_buffer #(
    .DW (DW)
  ) u_buf (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .in_valid  (i_problem_valid),
    .in_data   (i_problem),
    .in_ready  (o_problem_ready),
    .consume   (consume),
    .out_valid (buf_valid),
    .out_data  (buf_data)
  );

  assign o_answer_ready = (state_q == S_IDLE) && buf_valid;
  assign ans_take       = o_answer_ready && i_answer_valid;
  assign exp_nib        = rows_q[ACTIVE_ROW][ANS_NIBBLE*4 +: 4];
  assign match          = (i_answer_digit == exp_nib);
  assign disp_sum       = {1'b0, disp_q} + 12'(SCROLL_STEP);

  always_comb begin
    state_d     = state_q;
    prime_idx_d = prime_idx_q;
    rows_d      = rows_q;
    mark_d      = mark_q;
    marked_d    = marked_q;
    disp_d      = disp_q;
    score_d     = score_q;
    consume     = 1'b0;
    unique case (state_q)
      S_PRIME: begin
        if (buf_valid) begin
          rows_d[prime_idx_q] = buf_data;
          consume             = 1'b1;
          if (prime_idx_q == PW'(1)) begin
            state_d = S_IDLE;
          end else begin
            prime_idx_d = prime_idx_q - PW'(1);
          end
        end
      end
      S_IDLE: begin
        if (ans_take) begin
          rows_d[ACTIVE_ROW][ANS_NIBBLE*4 +: 4] = i_answer_digit;
          mark_d[ACTIVE_ROW]   = match;
          marked_d[ACTIVE_ROW] = 1'b1;
          rows_d[0]            = buf_data;
          consume              = 1'b1;
          if (match && (score_q != {SCORE_W{1'b1}})) begin
            score_d = score_q + SCORE_W'(1);
          end
          state_d = S_SCROLL;
        end
      end
      S_SCROLL: begin
        if (i_frame_tick) begin
          if (disp_sum >= 12'(ROW_HEIGHT)) begin
            for (int r = ROWS-1; r > 0; r--) begin
              rows_d[r] = rows_q[r-1];
            end
            rows_d[0] = BLANK_ROW;
            mark_d    = {mark_q[ROWS-2:0], 1'b0};
            marked_d  = {marked_q[ROWS-2:0], 1'b0};
            disp_d    = '0;
            state_d   = S_IDLE;
          end else begin
            disp_d = disp_sum[10:0];
          end
        end
      end
      default: state_d = S_PRIME;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_PRIME;
      prime_idx_q <= PRIME_START;
      for (int r = 0; r < ROWS; r++) begin
        rows_q[r] <= RESET_ROW;
      end
      mark_q      <= '0;
      marked_q    <= '0;
      disp_q      <= '0;
      score_q     <= '0;
    end else begin
      state_q     <= state_d;
      prime_idx_q <= prime_idx_d;
      rows_q      <= rows_d;
      mark_q      <= mark_d;
      marked_q    <= marked_d;
      disp_q      <= disp_d;
      score_q     <= score_d;
    end
  end

  for (genvar g = 0; g < ROWS; g++) begin : g_rows
    assign o_rows[g*DW +: DW] = rows_q[g];
  end

  assign o_mark         = mark_q;
  assign o_marked       = marked_q;
  assign o_displacement = disp_q;
  assign o_score        = score_q;
  assign o_busy         = (state_q != S_IDLE);

endmodule
